// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and enumerations.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   // ALU opcodes as driven by decode
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_t;

   // Operand source chosen by a forwarding mux
   typedef enum logic [1:0] {
      FWD_REG   = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_t;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Three-way operand forwarding selector for one source register.
// EX/MEM is the younger result and wins over MEM/WB; x0 is never forwarded.
module fwd_mux
   import cpu_pkg::*;
#(
   parameter int XLEN = cpu_pkg::XLEN,
   parameter int RA_W = cpu_pkg::RA_W
) (
   input  logic [RA_W-1:0] rs,
   input  logic [XLEN-1:0] rs_data,
   input  logic [RA_W-1:0] exmem_rd,
   input  logic            exmem_reg_write,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [RA_W-1:0] memwb_rd,
   input  logic            memwb_reg_write,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] fwd_data
);

   fwd_sel_t sel;

   // Pick the youngest in-flight producer of rs
   always_comb begin
      sel = FWD_REG;
      if (rs != '0) begin
         if (exmem_reg_write && (exmem_rd == rs))      sel = FWD_EXMEM;
         else if (memwb_reg_write && (memwb_rd == rs)) sel = FWD_MEMWB;
      end
   end

   // Route the selected source
   always_comb begin
      case (sel)
         FWD_EXMEM: fwd_data = exmem_result;
         FWD_MEMWB: fwd_data = memwb_result;
         default:   fwd_data = rs_data;
      endcase
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// ALU operands are combinational from the stage registers plus the current
// EX/MEM and MEM/WB forward sources.
module ex_operand_stage
   import cpu_pkg::*;
#(
   parameter int XLEN = cpu_pkg::XLEN,
   parameter int RA_W = cpu_pkg::RA_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic [RA_W-1:0] id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [2:0]      id_alu_ctrl,
   input  logic            id_alu_src,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            stall,
   input  logic            flush,
   input  logic [RA_W-1:0] exmem_rd,
   input  logic            exmem_reg_write,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [RA_W-1:0] memwb_rd,
   input  logic            memwb_reg_write,
   input  logic [XLEN-1:0] memwb_result,
   output logic [2:0]      ALUctrl,
   output logic [XLEN-1:0] ALUop1,
   output logic [XLEN-1:0] ALUop2,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic [RA_W-1:0] ex_rd,
   output logic [XLEN-1:0] ex_store_data,
   output logic            load_use_stall
);

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            mem_read;
      logic [RA_W-1:0] rd;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      alu_op_t         alu_ctrl;
      logic            alu_src;
   } ex_stage_t;

   ex_stage_t ex;

   logic [1:0][RA_W-1:0] src_rs;
   logic [1:0][XLEN-1:0] src_data;
   logic [1:0][XLEN-1:0] fwd_data;

   // Load in EX whose destination is read by the instruction in decode
   always_comb begin
      load_use_stall = ex.valid && ex.mem_read && (ex.rd != '0) && id_valid &&
                       ((ex.rd == id_rs1) || (ex.rd == id_rs2));
   end

   // Stage register: flush > stall > load-use bubble > capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex <= '0;
      end else if (flush) begin
         ex <= '0;
      end else if (stall) begin
         ex <= ex;
      end else if (load_use_stall) begin
         ex <= '0;
      end else begin
         ex.valid     <= id_valid;
         ex.reg_write <= id_valid && id_reg_write;
         ex.mem_read  <= id_valid && id_mem_read;
         ex.rd        <= id_rd;
         ex.rs1       <= id_rs1;
         ex.rs2       <= id_rs2;
         ex.rs1_data  <= id_rs1_data;
         ex.rs2_data  <= id_rs2_data;
         ex.imm       <= id_imm;
         ex.alu_ctrl  <= alu_op_t'(id_alu_ctrl);
         ex.alu_src   <= id_alu_src;
      end
   end

   assign src_rs[0]   = ex.rs1;
   assign src_rs[1]   = ex.rs2;
   assign src_data[0] = ex.rs1_data;
   assign src_data[1] = ex.rs2_data;

   genvar s;
   generate
      for (s = 0; s < 2; s++) begin : g_fwd
         fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
            .rs              (src_rs[s]),
            .rs_data         (src_data[s]),
            .exmem_rd        (exmem_rd),
            .exmem_reg_write (exmem_reg_write),
            .exmem_result    (exmem_result),
            .memwb_rd        (memwb_rd),
            .memwb_reg_write (memwb_reg_write),
            .memwb_result    (memwb_result),
            .fwd_data        (fwd_data[s])
         );
      end
   endgenerate

   // ALU-facing operands; store data bypasses the immediate mux
   always_comb begin
      ALUctrl       = ex.alu_ctrl;
      ALUop1        = fwd_data[0];
      ALUop2        = ex.alu_src ? ex.imm : fwd_data[1];
      ex_store_data = fwd_data[1];
      ex_valid      = ex.valid;
      ex_reg_write  = ex.reg_write;
      ex_mem_read   = ex.mem_read;
      ex_rd         = ex.rd;
   end

endmodule
